// File: rtl/xbar_pkg.sv
// Shared types for the crossbar master port: command record, FSM states, slave-select width.
package xbar_pkg;

    localparam int unsigned SLAVES      = 4;
    localparam int unsigned SLAVE_SEL_W = $clog2(SLAVES);

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xb_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_RESP,
        RSP_OUT
    } mport_state_t;

endpackage

// File: rtl/xbar_cmd_fifo.sv
// Command FIFO for the master port; wrap-bit pointers, registered head read from storage.
module xbar_cmd_fifo
    import xbar_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = xb_cmd_t
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output T     o_head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    T            r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/xbar_master_port.sv
// Master-side front end for one crossbar lane: buffers client commands, issues one at a time.
// Optional watchdog enabled by defining XBAR_MASTER_PORT_TIMEOUT_EN.
module xbar_master_port
    import xbar_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic        o_rsp_write,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_xb_req,
    output logic        o_xb_cmd,
    output logic [31:0] o_xb_addr,
    output logic [31:0] o_xb_wdata,
    input  logic        i_xb_ack,
    input  logic        i_xb_resp,
    input  logic [31:0] i_xb_rdata
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("xbar_master_port: DEPTH must be a power of 2 and >= 2");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("xbar_master_port: TIMEOUT_CYCLES must be >= 1");
    end

    mport_state_t r_state;
    mport_state_t w_state_next;

    xb_cmd_t     w_fifo_in;
    xb_cmd_t     w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_cap_rdata;
    logic        w_clr_rdata;
    logic        w_timeout;

    logic        r_xb_req;
    logic        r_xb_cmd;
    logic [31:0] r_xb_addr;
    logic [31:0] r_xb_wdata;
    logic        r_cur_write;
    logic [31:0] r_rdata;

    assign w_fifo_in = '{write: i_cmd_write, addr: i_cmd_addr, wdata: i_cmd_wdata};
    assign w_push    = i_cmd_valid && o_cmd_ready;

    xbar_cmd_fifo #(
        .DEPTH (DEPTH),
        .T     (xb_cmd_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_fifo_in),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

`ifdef XBAR_MASTER_PORT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;
    logic          w_tmo_hit;

    assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Any state change restarts the count, which covers entry to both wait states.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_tmo_cnt <= '0;
            end else if (r_state == WAIT_ACK || r_state == WAIT_RESP) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_pop)          r_err <= 1'b0;
            else if (w_timeout) r_err <= 1'b1;
        end
    end

    assign o_rsp_err = r_err;
`else
    assign o_rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_cap_rdata  = 1'b0;
        w_clr_rdata  = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (i_xb_ack) begin
                    w_state_next = r_cur_write ? RSP_OUT : WAIT_RESP;
                    w_clr_rdata  = r_cur_write;
                end
`ifdef XBAR_MASTER_PORT_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_next = RSP_OUT;
                    w_clr_rdata  = 1'b1;
                    w_timeout    = 1'b1;
                end
`endif
            end
            WAIT_RESP: begin
                if (i_xb_resp) begin
                    w_state_next = RSP_OUT;
                    w_cap_rdata  = 1'b1;
                end
`ifdef XBAR_MASTER_PORT_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_next = RSP_OUT;
                    w_clr_rdata  = 1'b1;
                    w_timeout    = 1'b1;
                end
`endif
            end
            RSP_OUT: begin
                if (i_rsp_ready) w_state_next = IDLE;
            end
        endcase
    end

    // Crossbar-side fields hold after the req pulse; wdata only moves on writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xb_req    <= 1'b0;
            r_xb_cmd    <= 1'b0;
            r_xb_addr   <= '0;
            r_xb_wdata  <= '0;
            r_cur_write <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_xb_req <= w_pop;
            if (w_pop) begin
                r_xb_cmd    <= w_head.write;
                r_xb_addr   <= w_head.addr;
                r_cur_write <= w_head.write;
                if (w_head.write) r_xb_wdata <= w_head.wdata;
            end
            if (w_cap_rdata)      r_rdata <= i_xb_rdata;
            else if (w_clr_rdata) r_rdata <= '0;
        end
    end

    assign o_cmd_ready = !w_full;
    assign o_rsp_valid = (r_state == RSP_OUT);
    assign o_rsp_write = r_cur_write;
    assign o_rsp_rdata = r_rdata;
    assign o_xb_req    = r_xb_req;
    assign o_xb_cmd    = r_xb_cmd;
    assign o_xb_addr   = r_xb_addr;
    assign o_xb_wdata  = r_xb_wdata;

endmodule

// File: tb/tb_xbar_master_port.sv
// Directed bench for xbar_master_port; timeout scenario runs when XBAR_MASTER_PORT_TIMEOUT_EN is set.
module tb_xbar_master_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;
    logic        xb_req, xb_cmd, xb_ack, xb_resp;
    logic [31:0] xb_addr, xb_wdata, xb_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xbar_master_port #(
        .DEPTH          (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_write (cmd_write),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_wdata (cmd_wdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_write (rsp_write),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .o_xb_req    (xb_req),
        .o_xb_cmd    (xb_cmd),
        .o_xb_addr   (xb_addr),
        .o_xb_wdata  (xb_wdata),
        .i_xb_ack    (xb_ack),
        .i_xb_resp   (xb_resp),
        .i_xb_rdata  (xb_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b1) begin failures++;
            $display("FAIL rst_cmd_ready got=%0b exp=1", cmd_ready); end
        checks++; if ({rsp_valid, rsp_write, rsp_err, xb_req, xb_cmd} !== 5'b0) begin failures++;
            $display("FAIL rst_ctrl_outs got=%b exp=00000",
                     {rsp_valid, rsp_write, rsp_err, xb_req, xb_cmd}); end
        checks++; if ({xb_addr, xb_wdata, rsp_rdata} !== 96'h0) begin failures++;
            $display("FAIL rst_data_outs got=%h exp=0", {xb_addr, xb_wdata, rsp_rdata}); end
        rst = 1'b0;
        tick();
        checks++; if (xb_req !== 1'b0 || rsp_valid !== 1'b0) begin failures++;
            $display("FAIL rst_idle got=%b%b exp=00", xb_req, rsp_valid); end
    endtask

    task automatic test_write();
        set_cmd(1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++; if ({xb_req, xb_cmd} !== 2'b11) begin failures++;
            $display("FAIL wr_req got=%b exp=11", {xb_req, xb_cmd}); end
        checks++; if (xb_addr !== 32'h4000_0010 || xb_wdata !== 32'hDEAD_BEEF) begin failures++;
            $display("FAIL wr_fields got=%h/%h exp=40000010/deadbeef", xb_addr, xb_wdata); end
        tick();
        checks++; if (xb_req !== 1'b0) begin failures++;
            $display("FAIL wr_req_pulse got=%0b exp=0", xb_req); end
        xb_ack = 1'b1;
        tick();
        xb_ack = 1'b0;
        checks++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b110 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL wr_rsp got=%b/%h exp=110/0", {rsp_valid, rsp_write, rsp_err}, rsp_rdata);
        end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++;
            $display("FAIL wr_rsp_done got=%0b exp=0", rsp_valid); end
    endtask

    task automatic test_read();
        set_cmd(1'b0, 32'hC000_0004, 32'h0BAD_0BAD);
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++; if ({xb_req, xb_cmd} !== 2'b10 || xb_addr !== 32'hC000_0004) begin failures++;
            $display("FAIL rd_req got=%b/%h exp=10/c0000004", {xb_req, xb_cmd}, xb_addr); end
        checks++; if (xb_wdata !== 32'hDEAD_BEEF) begin failures++;
            $display("FAIL rd_wdata_hold got=%h exp=deadbeef", xb_wdata); end
        // A resp before the ack must not complete the read.
        xb_resp  = 1'b1;
        xb_rdata = 32'hFFFF_0000;
        tick();
        xb_resp  = 1'b0;
        tick();
        xb_ack = 1'b1;
        tick();
        xb_ack = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin failures++;
            $display("FAIL rd_stray_resp got=%0b exp=0", rsp_valid); end
        tick();
        xb_resp  = 1'b1;
        xb_rdata = 32'h1234_5678;
        tick();
        xb_resp = 1'b0;
        checks++; if ({rsp_valid, rsp_write} !== 2'b10 || rsp_rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL rd_rsp got=%b/%h exp=10/12345678", {rsp_valid, rsp_write}, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_hold();
        rsp_ready = 1'b0;
        set_cmd(1'b0, 32'h8000_0020, 32'h0);
        tick();
        set_cmd(1'b0, 32'h8000_0024, 32'h0);
        tick();
        cmd_valid = 1'b0;
        checks++; if (xb_req !== 1'b1 || xb_addr !== 32'h8000_0020) begin failures++;
            $display("FAIL hold_req_a got=%0b/%h exp=1/80000020", xb_req, xb_addr); end
        tick();
        xb_ack = 1'b1;
        tick();
        xb_ack   = 1'b0;
        xb_resp  = 1'b1;
        xb_rdata = 32'h55AA_00FF;
        tick();
        xb_resp = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h55AA_00FF || rsp_write !== 1'b0 ||
                xb_req !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable[%0d] got=%b/%h/%b/%b exp=1/55aa00ff/0/0", k,
                         rsp_valid, rsp_rdata, rsp_write, xb_req);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0 || xb_req !== 1'b0) begin failures++;
            $display("FAIL hold_release got=%b%b exp=00", rsp_valid, xb_req); end
        tick();
        checks++; if (xb_req !== 1'b1 || xb_addr !== 32'h8000_0024) begin failures++;
            $display("FAIL hold_next_req got=%0b/%h exp=1/80000024", xb_req, xb_addr); end
        tick();
        xb_ack = 1'b1;
        tick();
        xb_ack   = 1'b0;
        xb_resp  = 1'b1;
        xb_rdata = 32'h0000_0BB0;
        tick();
        xb_resp = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_0BB0) begin failures++;
            $display("FAIL hold_b_rsp got=%0b/%h exp=1/00000bb0", rsp_valid, rsp_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        // Park a dummy write in WAIT_ACK so the FIFO can fill.
        set_cmd(1'b1, 32'h0000_0200, 32'h0000_AAAA);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 32'h100 + i, 32'h1000_0000 + i);
            checks++; if (cmd_ready !== 1'b1) begin failures++;
                $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, cmd_ready); end
            tick();
        end
        checks++; if (cmd_ready !== 1'b0) begin failures++;
            $display("FAIL b2b_full got=%0b exp=0", cmd_ready); end
        set_cmd(1'b1, 32'h104, 32'h1000_0004);
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b0) begin failures++;
            $display("FAIL b2b_full_hold got=%0b exp=0", cmd_ready); end
        xb_ack = 1'b1;
        tick();
        xb_ack = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin failures++;
            $display("FAIL b2b_dummy_rsp got=%0b exp=1", rsp_valid); end
        tick();
        tick();
        checks++; if (xb_req !== 1'b1 || xb_addr !== 32'h100 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_pop got=%0b/%h/%0b exp=1/00000100/1", xb_req, xb_addr,
                     cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks++; if (xb_req !== 1'b0 || cmd_ready !== 1'b0) begin failures++;
            $display("FAIL b2b_fifth_push got=%b%b exp=00", xb_req, cmd_ready); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                checks++;
                if (xb_req !== 1'b1 || xb_cmd !== 1'b1 || xb_addr !== 32'h100 + i ||
                    xb_wdata !== 32'h1000_0000 + i) begin
                    failures++;
                    $display("FAIL b2b_issue[%0d] got=%b%b/%h/%h exp=11/%h/%h", i, xb_req, xb_cmd,
                             xb_addr, xb_wdata, 32'h100 + i, 32'h1000_0000 + i);
                end
                tick();
                checks++; if (xb_req !== 1'b0) begin failures++;
                    $display("FAIL b2b_pulse[%0d] got=%0b exp=0", i, xb_req); end
            end
            xb_ack = 1'b1;
            tick();
            xb_ack = 1'b0;
            checks++; if ({rsp_valid, rsp_write} !== 2'b11) begin failures++;
                $display("FAIL b2b_rsp[%0d] got=%b exp=11", i, {rsp_valid, rsp_write}); end
            tick();
        end
        tick();
        checks++; if (xb_req !== 1'b0 || cmd_ready !== 1'b1) begin failures++;
            $display("FAIL b2b_drained got=%b%b exp=01", xb_req, cmd_ready); end
    endtask

    task automatic test_reset_mid();
        set_cmd(1'b0, 32'h4000_0040, 32'h0);
        tick();
        set_cmd(1'b0, 32'h4000_0044, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        xb_ack = 1'b1;
        tick();
        xb_ack = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || xb_addr !== 32'h0) begin
            failures++;
            $display("FAIL mid_rst_state got=%0b/%0b/%h exp=0/1/0", rsp_valid, cmd_ready, xb_addr);
        end
        for (int k = 0; k < 6; k++) begin
            xb_resp  = (k == 2);
            xb_rdata = 32'h7777_7777;
            tick();
            checks++; if (xb_req !== 1'b0 || rsp_valid !== 1'b0) begin failures++;
                $display("FAIL mid_rst_quiet[%0d] got=%b%b exp=00", k, xb_req, rsp_valid); end
        end
        xb_resp = 1'b0;
    endtask

`ifdef XBAR_MASTER_PORT_TIMEOUT_EN
    task automatic test_timeout();
        rsp_ready = 1'b0;
        set_cmd(1'b0, 32'h4000_0080, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int k = 1; k < 8; k++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0) begin failures++;
                $display("FAIL tmo_early[%0d] got=%0b exp=0", k, rsp_valid); end
        end
        tick();
        checks++; if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'h0) begin failures++;
            $display("FAIL tmo_rsp got=%b/%h exp=11/0", {rsp_valid, rsp_err}, rsp_rdata); end
        rsp_ready = 1'b1;
        tick();
        xb_ack = 1'b1;
        tick();
        xb_ack  = 1'b0;
        xb_resp = 1'b1;
        tick();
        xb_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0 || xb_req !== 1'b0) begin failures++;
                $display("FAIL tmo_late_ack[%0d] got=%b%b exp=00", k, rsp_valid, xb_req); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        xb_ack    = 1'b0;
        xb_resp   = 1'b0;
        xb_rdata  = '0;
        test_reset();
        test_write();
        test_read();
        test_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef XBAR_MASTER_PORT_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xbar_master_port.md
Name: xbar_master_port

Overview:
- Master-side front end that sits directly upstream of one crossbar master lane.
- Accepts commands from a local client over a valid/ready handshake and buffers them in a small FIFO.
- Issues each command to the crossbar as a single-cycle req pulse, then tracks ack/resp.
- Returns one completion record per command to the client. One crossbar transaction is outstanding at a time, so the crossbar's per-master cell is always empty when req fires and no command is dropped.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  client command valid
- cmd_ready  out  1  FIFO not full
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  address; top $clog2(SLAVES) bits select the slave
- cmd_wdata  in  32  write data
- rsp_valid  out  1  completion valid
- rsp_ready  in  1  client accepts completion
- rsp_write  out  1  completion is for a write
- rsp_rdata  out  32  read data (0 for writes)
- rsp_err  out  1  timeout completion (tied 0 without the optional feature)
- xb_req  out  1  to mif.req[i]
- xb_cmd  out  1  to mif.cmd[i]
- xb_addr  out  32  to mif.addr[i]
- xb_wdata  out  32  to mif.wdata[i]
- xb_ack  in  1  from mif.ack[i]
- xb_resp  in  1  from mif.resp[i]
- xb_rdata  in  32  from mif.rdata[i]

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1; FIFO empty; FSM in IDLE.
- Client push: a command is pushed when cmd_valid && cmd_ready. cmd_ready = !full, registered. The FIFO has 1-cycle latency: a push at edge N is poppable at edge N+1.
- FSM states IDLE, WAIT_ACK, WAIT_RESP, RSP_OUT:
  - IDLE: if FIFO non-empty, pop. xb_req<=1 for exactly one cycle; xb_cmd/xb_addr/xb_wdata <= head entry. Latch cmd in cur_write. Go to WAIT_ACK.
  - WAIT_ACK: on xb_ack, a write goes to RSP_OUT (rsp_rdata=0) and a read goes to WAIT_RESP.
  - WAIT_RESP: on xb_resp, capture xb_rdata, go to RSP_OUT.
  - RSP_OUT: rsp_valid=1 with fields held stable until rsp_ready. On the handshake, go to IDLE.
- Minimum command-to-completion turnaround is 1 cycle between handshake and next issue: the next pop can happen the cycle after the rsp handshake.
- xb_addr and xb_wdata hold their last value after the req pulse. xb_wdata is updated only for writes.
- Stray input pulses: xb_ack outside WAIT_ACK is ignored, and xb_resp outside WAIT_RESP is ignored.
- FIFO boundaries:
  - Full: cmd_ready=0 and cmd_valid is ignored.
  - Push and pop in the same cycle while full: the push is still refused, because cmd_ready is registered.
  - Push and pop in the same cycle while empty: legal only when the entry is already present, so no fall-through.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit. Full = MSBs differ and the remaining bits are equal.
- Reset mid-transaction: the FSM returns to IDLE and the FIFO is flushed. Late xb_ack/xb_resp from the aborted transaction are ignored by the stray-pulse rule. The crossbar is reset on the same rst.

Optional Feature:
- Macro XBAR_MASTER_PORT_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to WAIT_ACK/WAIT_RESP and increments each cycle in those states.
  - On reaching TIMEOUT_CYCLES, the FSM goes to RSP_OUT with rsp_err=1 and rsp_rdata=0.
  - Any ack/resp arriving afterwards for that transaction is ignored.
- Disabled: no counter; rsp_err is tied 0; the block waits indefinitely.

Decomposition:
- Package xbar_pkg holds:
  - localparam SLAVE_SEL_W = $clog2(SLAVES)
  - typedef xb_cmd_t struct {write, addr[31:0], wdata[31:0]}
  - typedef enum mport_state_t {IDLE, WAIT_ACK, WAIT_RESP, RSP_OUT}
- Sub-module xbar_cmd_fifo: parameterised on DEPTH and element type xb_cmd_t; ports push/pop/full/empty/head.

Test Plan:
- Single write, addr 0x4000_0010, wdata 0xDEAD_BEEF -> one-cycle xb_req with xb_cmd=1 and matching addr/wdata. xb_ack pulse -> rsp_valid with rsp_write=1, rsp_rdata=0.
- Single read, addr 0xC000_0004 -> xb_req pulse with xb_cmd=0. Ack 3 cycles later, resp with xb_rdata=0x1234_5678 2 cycles after that -> rsp_rdata=0x1234_5678.
- Push 5 commands back-to-back with DEPTH=4 -> cmd_ready drops after the 4th accept. The 5th is accepted after the first pop. All 5 are issued in order, each as exactly one req pulse.
- Hold rsp_ready=0 for 10 cycles on a read completion -> rsp fields stable, no new xb_req. Release -> next command issues the following cycle.
- Assert rst in WAIT_RESP, then pulse xb_resp 2 cycles after reset -> no rsp_valid, cmd_ready=1, FIFO empty.
- With TIMEOUT_EN and TIMEOUT_CYCLES=8, never ack a read -> rsp_valid with rsp_err=1 after 8 cycles in WAIT_ACK. A later xb_ack produces no further response.
